// File: rtl/dmem_block_responder.sv
// Main-memory block responder for the data cache: one 128-bit block per transaction,
// fixed access latency, busywait handshake, sticky error on conflicting read/write requests.
module dmem_block_responder #(
    parameter int LATENCY = 5,
    parameter int ADDR_W  = 6,
    parameter int BLOCK_W = 128
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [ADDR_W-1:0]  mem_address,
    input  logic [BLOCK_W-1:0] mem_writedata,
    output logic [BLOCK_W-1:0] mem_readdata,
    output logic               mem_busywait,
    output logic               mem_error
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt;
    logic               op_write;
    logic [ADDR_W-1:0]  addr_q;
    logic [BLOCK_W-1:0] data_q;
    logic               capture;
    logic               access;

    logic [BLOCK_W-1:0] store [2**ADDR_W];

    always_comb begin
        state_next   = state;
        mem_busywait = 1'b0;
        capture      = 1'b0;
        access       = 1'b0;
        case (state)
            IDLE: begin
                // Busywait rises in the same cycle the cache raises its request.
                mem_busywait = mem_read | mem_write;
                if (mem_read | mem_write) begin
                    capture    = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                mem_busywait = 1'b1;
                if (cnt == '0) begin
                    access     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (reset) begin
            mem_busywait = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            mem_readdata <= '0;
            mem_error    <= 1'b0;
        end else begin
            state <= state_next;
            if (capture) begin
                // A simultaneous read+write is serviced as a write.
                op_write <= mem_write;
                addr_q   <= mem_address;
                data_q   <= mem_writedata;
                cnt      <= CNT_W'(LATENCY - 1);
                if (mem_read && mem_write) begin
                    mem_error <= 1'b1;
                end
            end else if (state == BUSY && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (access && !op_write) begin
                mem_readdata <= store[addr_q];
            end
        end
    end

    // Backing store is never cleared; a reset edge suppresses a pending write.
    always_ff @(posedge clk) begin
        if (access && op_write && !reset) begin
            store[addr_q] <= data_q;
        end
    end

endmodule

// File: tb/tb_dmem_block_responder.sv
// Self-checking bench for dmem_block_responder: directed handshake cases plus random
// block reads/writes scored against an array-based memory model.
module tb_dmem_block_responder;

    localparam int LATENCY = 5;
    localparam int ADDR_W  = 6;
    localparam int BLOCK_W = 128;
    localparam int DEPTH   = 2**ADDR_W;

    logic               clk = 1'b0;
    logic               reset;
    logic               mem_read;
    logic               mem_write;
    logic [ADDR_W-1:0]  mem_address;
    logic [BLOCK_W-1:0] mem_writedata;
    logic [BLOCK_W-1:0] mem_readdata;
    logic               mem_busywait;
    logic               mem_error;

    dmem_block_responder #(
        .LATENCY(LATENCY),
        .ADDR_W (ADDR_W),
        .BLOCK_W(BLOCK_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .mem_writedata(mem_writedata),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait),
        .mem_error    (mem_error)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: plain block array plus last-read and sticky-error state.
    logic [BLOCK_W-1:0] model_mem [DEPTH];
    bit                 written   [DEPTH];
    logic [BLOCK_W-1:0] model_rd;
    logic               model_err;

    task automatic chk(input string tag, input logic [BLOCK_W-1:0] got, input logic [BLOCK_W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [BLOCK_W-1:0] rand_block();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called at a negedge while the DUT is idle; returns at the negedge of the cycle after DONE.
    task automatic do_txn(input bit rd, input bit wr, input logic [ADDR_W-1:0] a,
                          input logic [BLOCK_W-1:0] d, input bit scramble, input bit hold);
        int busy;
        bit done;
        mem_read      = rd;
        mem_write     = wr;
        mem_address   = a;
        mem_writedata = d;
        #1 chk("busywait_same_cycle", mem_busywait, 1);
        if (wr) begin
            model_mem[a] = d;
            written[a]   = 1'b1;
            if (rd) model_err = 1'b1;
        end else begin
            model_rd = model_mem[a];
        end
        busy = 1;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (mem_busywait) begin
                busy++;
                if (scramble) begin
                    mem_address   = ADDR_W'($urandom);
                    mem_writedata = rand_block();
                end
            end else begin
                done = 1'b1;
            end
        end
        chk("done_reached", done, 1);
        chk("busy_cycles", busy, LATENCY + 1);
        chk("readdata", mem_readdata, model_rd);
        chk("error", mem_error, model_err);
        if (!hold) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end
        @(negedge clk);
        #1 chk(hold ? "held_restarts" : "dropped_stays_idle", mem_busywait, hold);
    endtask

    initial begin
        logic [ADDR_W-1:0]  a;
        logic [BLOCK_W-1:0] blk;
        int                 tries;

        for (int i = 0; i < DEPTH; i++) written[i] = 1'b0;
        model_rd      = '0;
        model_err     = 1'b0;
        reset         = 1'b1;
        mem_read      = 1'b1;
        mem_write     = 1'b0;
        mem_address   = '0;
        mem_writedata = '0;

        // Reset state with a read pending
        repeat (3) @(negedge clk);
        chk("rst_busywait", mem_busywait, 0);
        chk("rst_readdata", mem_readdata, 0);
        chk("rst_error", mem_error, 0);
        reset = 1'b0;
        #1 chk("post_rst_busywait", mem_busywait, 1);
        // Turn the pending request into a write before the capturing edge.
        do_txn(0, 1, 6'd0, rand_block(), 0, 0);

        // Write then read the same block
        blk = 128'hDDDD_CCCC_BBBB_AAAA_1111_2222_3333_4444;
        do_txn(0, 1, 6'd3, blk, 0, 0);
        chk("write_keeps_readdata", mem_readdata, 0);
        do_txn(1, 0, 6'd3, '0, 0, 0);
        chk("readback_addr3", mem_readdata, blk);

        // Held read restarts; dropped read does not
        do_txn(1, 0, 6'd3, '0, 0, 1);
        do_txn(1, 0, 6'd3, '0, 0, 0);

        // Latched address/data survive input changes mid-BUSY
        do_txn(0, 1, 6'd9, rand_block(), 1, 0);
        do_txn(1, 0, 6'd9, '0, 1, 0);
        a = ADDR_W'(64);
        do_txn(0, 1, a, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 0, 0);
        do_txn(1, 0, 6'd0, '0, 0, 0);
        chk("alias_64_to_0", mem_readdata, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);

        // Random traffic
        for (int n = 0; n < 24; n++) begin
            a = ADDR_W'($urandom);
            if ($urandom_range(1, 0) == 1) begin
                do_txn(0, 1, a, rand_block(), $urandom_range(1, 0) == 1, 0);
            end else begin
                tries = 0;
                while (!written[a] && tries < 200) begin
                    a = ADDR_W'($urandom);
                    tries++;
                end
                do_txn(1, 0, a, '0, $urandom_range(1, 0) == 1, 0);
            end
        end

        // Simultaneous read+write: serviced as write, error sticks
        blk = rand_block();
        do_txn(1, 1, 6'd7, blk, 0, 0);
        do_txn(1, 0, 6'd7, '0, 0, 0);
        chk("rw_conflict_written", mem_readdata, blk);
        do_txn(0, 1, 6'd12, rand_block(), 0, 0);
        chk("error_sticky", mem_error, 1);

        // Reset mid-BUSY aborts the write
        mem_write     = 1'b1;
        mem_address   = 6'd9;
        mem_writedata = rand_block();
        @(negedge clk);
        @(negedge clk);
        mem_write = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        chk("midbusy_rst_busywait", mem_busywait, 0);
        chk("midbusy_rst_error", mem_error, 0);
        chk("midbusy_rst_readdata", mem_readdata, 0);
        reset     = 1'b0;
        model_rd  = '0;
        model_err = 1'b0;
        @(negedge clk);
        #1 chk("post_abort_idle", mem_busywait, 0);
        do_txn(1, 0, 6'd9, '0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
